instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the code-memory read interface. Owns the PC and issues word reads to the code memory.
- Waits a fixed memory latency, then captures the 32-bit instruction.
- Presents the instruction and its PC to decode with a valid/ready handshake.
- Handles branch redirects and out-of-range or misaligned fetch faults. Sits between the code memory and the decode stage.

Parameters:
- TEXT_BASE, 64'h0000_0000_0040_0000, first byte address of the .text region
- TEXT_END, 64'h0000_0000_0040_0FFF, last byte address of the .text region (inclusive)
- RESET_PC, 64'h0000_0000_0040_0000, PC loaded on reset
- MEM_LATENCY, 1, cycles from request to valid read data; legal range 1..7

Ports:
- iCLK  in  1  system clock
- iRST  in  1  synchronous active-high reset
- oMemAddress  out  64  code-memory byte address
- oMemReadEnable  out  1  code-memory read enable
- oMemByteEnable  out  4  always 4'b1111
- iMemReadData  in  32  code-memory read data; only the low word is used
- iRedirect  in  1  branch/jump redirect strobe
- iRedirectPC  in  64  redirect target
- oInstr  out  32  fetched instruction
- oPC  out  64  PC of oInstr
- oValid  out  1  oInstr/oPC are valid
- iReady  in  1  decode accepts when oValid&&iReady
- oFault  out  1  fetch fault (sticky until redirect)
- oFetchCount  out  32  perf counter (see Optional Feature)
- oStallCount  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (iRST sampled high at an iCLK edge):
  - PC=RESET_PC; state=REQ.
  - oValid=0, oFault=0, oMemReadEnable=0, oInstr=0, oPC=0, counters=0.
  - Reset mid-request discards any in-flight data.
- Address check (combinational on PC): ok = PC>=TEXT_BASE && PC<=TEXT_END-3 && PC[1:0]==0.
- FSM states REQ, WAIT, HOLD, FAULT:
  - REQ:
    - If !ok: go FAULT; no memory read is issued.
    - If ok: drive oMemAddress=PC and oMemReadEnable=1; load lat_cnt=MEM_LATENCY-1; go WAIT.
  - WAIT:
    - Hold oMemAddress and oMemReadEnable=1.
    - If lat_cnt!=0, decrement it.
    - If lat_cnt==0: capture oInstr=iMemReadData, oPC=PC; set oValid=1; PC=PC+4 (64-bit wrap, not checked until the next REQ); drop oMemReadEnable; go HOLD.
  - HOLD:
    - oValid=1; oInstr and oPC stable.
    - On oValid&&iReady: oValid=0, go REQ.
    - Otherwise stay.
  - FAULT:
    - oFault=1, oValid=0, oMemReadEnable=0.
    - Stay until iRedirect.
- Throughput: one instruction per MEM_LATENCY+2 cycles with iReady held high. Only one request is outstanding at a time.
- Redirect has priority over every state transition:
  - iRedirect=1 at an edge sets PC=iRedirectPC, oValid=0, oFault=0, and the next state is REQ.
  - Any in-flight read is abandoned; its data is never captured.
  - Redirect in the same cycle as a HOLD handshake: the handshake counts as accepted, and the redirect still applies.
  - Redirect during reset is ignored; reset wins.
- oMemAddress is 0 whenever oMemReadEnable=0.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - oFetchCount increments on each accepted handshake (oValid&&iReady).
  - oStallCount increments on each cycle with oValid&&!iReady.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Not defined: both outputs are tied to 32'h0 and no counter logic is synthesized.

Decomposition:
- Shared package fetch_pkg holds:
  - the fetch_state_t enum (REQ, WAIT, HOLD, FAULT)
  - INSTR_BYTES=4
  - BYTE_EN_WORD=4'b1111
  - the 64-bit address type
- One natural sub-module, fetch_addr_check: purely combinational range/alignment check parameterised by TEXT_BASE and TEXT_END. It is reused by the data-side checker.

Test Plan:
- Reset then iReady=1, memory returning 32'hAAAA0000+index, MEM_LATENCY=1 -> first oValid on cycle 3 after reset release, oPC=0x400000, oInstr=32'hAAAA0000; next oPC=0x400004 three cycles later.
- iReady=0 for 5 cycles while oValid=1 -> oInstr and oPC stable, no new oMemReadEnable; with FETCH_PERF_CNT_EN, oStallCount=5.
- iRedirect with iRedirectPC=0x400100 during WAIT -> in-flight data discarded; next oPC=0x400100.
- Sequential fetch from 0x400FFC -> instruction delivered, then the next REQ (PC=0x401000) gives oFault=1 with no read issued; iRedirect to 0x400000 clears oFault and fetch resumes.
- iRedirectPC=0x400002 (misaligned) -> oFault=1 one cycle later; oValid stays 0.
- MEM_LATENCY=3, iRST asserted during WAIT -> all outputs return to reset values; the first fetch after release is from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// The optional FETCH_PERF_CNT_EN build macro is consumed by instr_fetch_unit.
package fetch_pkg;

    typedef logic [63:0] addr_t;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int         INSTR_BYTES  = 4;
    localparam logic [3:0] BYTE_EN_WORD = 4'b1111;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational range/alignment check for a word access inside [TEXT_BASE, TEXT_END].
// Shared with the data-side checker, so it carries no fetch-specific state.
module fetch_addr_check
    import fetch_pkg::*;
#(
    parameter addr_t TEXT_BASE = 64'h0000_0000_0040_0000,
    parameter addr_t TEXT_END  = 64'h0000_0000_0040_0FFF
) (
    input  addr_t addr,
    output logic  ok
);

    // The whole 4-byte word must fit, hence the upper bound of TEXT_END-3.
    assign ok = (addr >= TEXT_BASE) &&
                (addr <= TEXT_END - addr_t'(3)) &&
                (addr[1:0] == 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one code-memory read at a time, hands words to decode.
// Define FETCH_PERF_CNT_EN to build the fetch/stall performance counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter addr_t TEXT_BASE   = 64'h0000_0000_0040_0000,
    parameter addr_t TEXT_END    = 64'h0000_0000_0040_0FFF,
    parameter addr_t RESET_PC    = 64'h0000_0000_0040_0000,
    parameter int    MEM_LATENCY = 1
) (
    input  logic         iCLK,
    input  logic         iRST,
    output logic [63:0]  oMemAddress,
    output logic         oMemReadEnable,
    output logic [3:0]   oMemByteEnable,
    input  logic [31:0]  iMemReadData,
    input  logic         iRedirect,
    input  logic [63:0]  iRedirectPC,
    output logic [31:0]  oInstr,
    output logic [63:0]  oPC,
    output logic         oValid,
    input  logic         iReady,
    output logic         oFault,
    output logic [31:0]  oFetchCount,
    output logic [31:0]  oStallCount,
    output fetch_state_t dbg_state
);

    // Handshake: oInstr/oPC transfer on a rising iCLK edge where oValid && iReady;
    // oValid, once set, holds with stable payload until that edge or a redirect.

    fetch_state_t state;
    addr_t        pc;
    logic [2:0]   lat_cnt;
    logic         addr_ok;

    fetch_addr_check #(
        .TEXT_BASE (TEXT_BASE),
        .TEXT_END  (TEXT_END)
    ) u_addr_check (
        .addr (pc),
        .ok   (addr_ok)
    );

    assign oMemByteEnable = BYTE_EN_WORD;
    assign dbg_state      = state;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state          <= REQ;
            pc             <= RESET_PC;
            lat_cnt        <= '0;
            oMemAddress    <= '0;
            oMemReadEnable <= 1'b0;
            oInstr         <= '0;
            oPC            <= '0;
            oValid         <= 1'b0;
            oFault         <= 1'b0;
        end else if (iRedirect) begin
            // Abandons any in-flight read; a same-cycle handshake has already transferred.
            state          <= REQ;
            pc             <= iRedirectPC;
            oMemAddress    <= '0;
            oMemReadEnable <= 1'b0;
            oValid         <= 1'b0;
            oFault         <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (!addr_ok) begin
                        oFault <= 1'b1;
                        state  <= FAULT;
                    end else begin
                        oMemAddress    <= pc;
                        oMemReadEnable <= 1'b1;
                        lat_cnt        <= 3'(MEM_LATENCY - 1);
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt != 3'd0) begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end else begin
                        oInstr         <= iMemReadData;
                        oPC            <= pc;
                        oValid         <= 1'b1;
                        pc             <= pc + addr_t'(INSTR_BYTES);
                        oMemAddress    <= '0;
                        oMemReadEnable <= 1'b0;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        state  <= REQ;
                    end
                end
                FAULT: begin
                    oValid         <= 1'b0;
                    oMemReadEnable <= 1'b0;
                    oMemAddress    <= '0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (oValid && iReady)  fetch_count <= fetch_count + 32'd1;
            if (oValid && !iReady) stall_count <= stall_count + 32'd1;
        end
    end

    assign oFetchCount = fetch_count;
    assign oStallCount = stall_count;
`else
    assign oFetchCount = 32'h0;
    assign oStallCount = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3.
// Counter expectations follow FETCH_PERF_CNT_EN when the bench is built with it.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 instance
    logic         rst = 1'b1, redirect = 1'b0, ready = 1'b1;
    logic [63:0]  redirect_pc = '0;
    logic [63:0]  mem_addr, pc;
    logic         mem_re, valid, fault;
    logic [3:0]   mem_be;
    logic [31:0]  mem_rdata, instr, fetch_cnt, stall_cnt;
    fetch_state_t state;

    // Latency-3 instance
    logic         rst_3 = 1'b1, redirect_3 = 1'b0, ready_3 = 1'b1;
    logic [63:0]  redirect_pc_3 = '0;
    logic [63:0]  mem_addr_3, pc_3;
    logic         mem_re_3, valid_3, fault_3;
    logic [3:0]   mem_be_3;
    logic [31:0]  mem_rdata_3, instr_3, fetch_cnt_3, stall_cnt_3;
    fetch_state_t state_3;

    instr_fetch_unit #(.MEM_LATENCY(LAT1)) u_dut (
        .iCLK(clk), .iRST(rst), .oMemAddress(mem_addr), .oMemReadEnable(mem_re),
        .oMemByteEnable(mem_be), .iMemReadData(mem_rdata), .iRedirect(redirect),
        .iRedirectPC(redirect_pc), .oInstr(instr), .oPC(pc), .oValid(valid),
        .iReady(ready), .oFault(fault), .oFetchCount(fetch_cnt),
        .oStallCount(stall_cnt), .dbg_state(state)
    );

    instr_fetch_unit #(.MEM_LATENCY(LAT3)) u_dut_3 (
        .iCLK(clk), .iRST(rst_3), .oMemAddress(mem_addr_3), .oMemReadEnable(mem_re_3),
        .oMemByteEnable(mem_be_3), .iMemReadData(mem_rdata_3), .iRedirect(redirect_3),
        .iRedirectPC(redirect_pc_3), .oInstr(instr_3), .oPC(pc_3), .oValid(valid_3),
        .iReady(ready_3), .oFault(fault_3), .oFetchCount(fetch_cnt_3),
        .oStallCount(stall_cnt_3), .dbg_state(state_3)
    );

    // Code memory: word index i holds 32'hAAAA0000+i; garbage until the latency has elapsed.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hAAAA0000 + 32'((a - 64'h40_0000) >> 2);
    endfunction

    int en_cnt = 0, en_cnt_3 = 0;
    always @(posedge clk) begin
        en_cnt   <= mem_re   ? en_cnt + 1   : 0;
        en_cnt_3 <= mem_re_3 ? en_cnt_3 + 1 : 0;
    end
    assign mem_rdata   = (mem_re   && en_cnt   >= LAT1 - 1) ? mem_word(mem_addr)   : 32'hDEADBEEF;
    assign mem_rdata_3 = (mem_re_3 && en_cnt_3 >= LAT3 - 1) ? mem_word(mem_addr_3) : 32'hDEADBEEF;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns the number of edges until oValid is seen, or -1 when the budget runs out.
    task automatic wait_valid(input bit use3, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((use3 ? valid_3 : valid) !== 1'b1) && n < 20);
        if ((use3 ? valid_3 : valid) !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; ready = 1'b1;
        tick(); tick();
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (fault !== 1'b0)   begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
        checks++; if (mem_re !== 1'b0)  begin errors++; $display("FAIL reset_re got %0b want 0", mem_re); end
        checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        checks++; if (instr !== 32'h0 || pc !== 64'h0) begin errors++; $display("FAIL reset_payload got %h/%h want 0/0", instr, pc); end
        checks++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
        checks++; if (mem_be !== 4'hF)  begin errors++; $display("FAIL byte_enable got %h want f", mem_be); end
        rst = 1'b0;
        tick();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 64'h40_0000) begin errors++; $display("FAIL first_req got re=%0b addr=%h want 1/400000", mem_re, mem_addr); end
        wait_valid(1'b0, n);
        // Release cycle counted as cycle 1, so valid appears in cycle 3 (second edge).
        checks++; if (n !== 1) begin errors++; $display("FAIL first_valid_latency got %0d want 1 more edge", n); end
        checks++; if (pc !== 64'h40_0000 || instr !== 32'hAAAA0000) begin errors++; $display("FAIL first_fetch got %h/%h want 400000/aaaa0000", pc, instr); end
        wait_valid(1'b0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL throughput got %0d want 3", n); end
        checks++; if (pc !== 64'h40_0004 || instr !== 32'hAAAA0001) begin errors++; $display("FAIL second_fetch got %h/%h want 400004/aaaa0001", pc, instr); end
    endtask

    task automatic test_stall();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || pc !== 64'h40_0004 || instr !== 32'hAAAA0001 || mem_re !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got v=%0b pc=%h instr=%h re=%0b", i, valid, pc, instr, mem_re);
            end
        end
        checks++; if (stall_cnt !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL stall_count got %0d want %0d", stall_cnt, PERF ? 5 : 0); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_release got %0b want 0", valid); end
        checks++; if (fetch_cnt !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL fetch_count got %0d want %0d", fetch_cnt, PERF ? 2 : 0); end
    endtask

    task automatic test_redirect_wait();
        int n;
        tick();
        checks++; if (mem_re !== 1'b1 || mem_addr !== 64'h40_0008) begin errors++; $display("FAIL wait_req got re=%0b addr=%h want 1/400008", mem_re, mem_addr); end
        redirect = 1'b1; redirect_pc = 64'h40_0100;
        tick();
        redirect = 1'b0;
        checks++; if (valid !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 64'h0) begin errors++; $display("FAIL redirect_abort got v=%0b re=%0b addr=%h want 0/0/0", valid, mem_re, mem_addr); end
        wait_valid(1'b0, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL redirect_latency got %0d want 2", n); end
        checks++; if (pc !== 64'h40_0100 || instr !== 32'hAAAA0040) begin errors++; $display("FAIL redirect_fetch got %h/%h want 400100/aaaa0040", pc, instr); end
    endtask

    task automatic test_end_of_text();
        int n;
        // Redirect lands on the same edge as the handshake of the 0x400100 word.
        redirect = 1'b1; redirect_pc = 64'h40_0FFC;
        tick();
        redirect = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redirect_hs_valid got %0b want 0", valid); end
        checks++; if (fetch_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL redirect_hs_count got %0d want %0d", fetch_cnt, PERF ? 3 : 0); end
        wait_valid(1'b0, n);
        checks++; if (n !== 2 || pc !== 64'h40_0FFC || instr !== 32'hAAAA03FF) begin errors++; $display("FAIL last_word got n=%0d %h/%h want 2 400ffc/aaaa03ff", n, pc, instr); end
        tick();
        checks++; if (valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL last_word_accept got v=%0b f=%0b want 0/0", valid, fault); end
        tick();
        checks++; if (fault !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 64'h0) begin errors++; $display("FAIL end_fault got f=%0b re=%0b addr=%h want 1/0/0", fault, mem_re, mem_addr); end
        checks++; if (state !== FAULT) begin errors++; $display("FAIL end_state got %0d want %0d", state, FAULT); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fault !== 1'b1 || mem_re !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL fault_sticky cyc %0d got f=%0b re=%0b v=%0b", i, fault, mem_re, valid); end
        end
        redirect = 1'b1; redirect_pc = 64'h40_0000;
        tick();
        redirect = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %0b want 0", fault); end
        wait_valid(1'b0, n);
        checks++; if (n !== 2 || pc !== 64'h40_0000 || instr !== 32'hAAAA0000) begin errors++; $display("FAIL resume got n=%0d %h/%h want 2 400000/aaaa0000", n, pc, instr); end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 64'h40_0002;
        tick();
        redirect = 1'b0;
        checks++; if (fault !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL misalign_pre got f=%0b v=%0b want 0/0", fault, valid); end
        tick();
        checks++; if (fault !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL misalign_fault got f=%0b re=%0b want 1/0", fault, mem_re); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL misalign_hold cyc %0d got v=%0b f=%0b", i, valid, fault); end
        end
        redirect = 1'b1; redirect_pc = 64'h3F_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (fault !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL below_base got f=%0b re=%0b want 1/0", fault, mem_re); end
    endtask

    task automatic test_reset_priority();
        int n;
        rst = 1'b1; redirect = 1'b1; redirect_pc = 64'h40_0100;
        tick();
        rst = 1'b0; redirect = 1'b0;
        checks++; if (fault !== 1'b0 || valid !== 1'b0 || pc !== 64'h0) begin errors++; $display("FAIL rst_vs_redirect got f=%0b v=%0b pc=%h", fault, valid, pc); end
        wait_valid(1'b0, n);
        checks++; if (n !== 2 || pc !== 64'h40_0000) begin errors++; $display("FAIL rst_wins got n=%0d pc=%h want 2 400000", n, pc); end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        rst_3 = 1'b1; ready_3 = 1'b1;
        tick();
        rst_3 = 1'b0;
        tick(); tick();
        checks++; if (mem_re_3 !== 1'b1 || mem_addr_3 !== 64'h40_0000 || valid_3 !== 1'b0) begin errors++; $display("FAIL lat3_wait got re=%0b addr=%h v=%0b", mem_re_3, mem_addr_3, valid_3); end
        rst_3 = 1'b1;
        tick();
        checks++;
        if (mem_re_3 !== 1'b0 || mem_addr_3 !== 64'h0 || valid_3 !== 1'b0 || fault_3 !== 1'b0 || pc_3 !== 64'h0 || instr_3 !== 32'h0) begin
            errors++; $display("FAIL lat3_reset got re=%0b addr=%h v=%0b f=%0b pc=%h instr=%h", mem_re_3, mem_addr_3, valid_3, fault_3, pc_3, instr_3);
        end
        rst_3 = 1'b0;
        wait_valid(1'b1, n);
        checks++; if (n !== 4 || pc_3 !== 64'h40_0000 || instr_3 !== 32'hAAAA0000) begin errors++; $display("FAIL lat3_first got n=%0d %h/%h want 4 400000/aaaa0000", n, pc_3, instr_3); end
        wait_valid(1'b1, n);
        checks++; if (n !== 5 || pc_3 !== 64'h40_0004 || instr_3 !== 32'hAAAA0001) begin errors++; $display("FAIL lat3_second got n=%0d %h/%h want 5 400004/aaaa0001", n, pc_3, instr_3); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_wait();
        test_end_of_text();
        test_misaligned();
        test_reset_priority();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
